ln_stats_stream: RTL and testbench



---
 rtl/ln_pkg.sv | 31 +++
 rtl/ln_lane_reducer.sv | 38 +++
 rtl/ln_stats_stream.sv | 155 +++++++++++++++
 tb/tb_ln_stats_stream.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_pkg.sv
// rtl/ln_pkg.sv - shared types, widths and helpers for the LayerNorm statistics engine
package ln_pkg;

    localparam int FRAC_IN  = 10;
    localparam int FRAC_VAR = 20;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_MEAN  = 2'd1,
        ST_VAR   = 2'd2,
        ST_OUT   = 2'd3
    } ln_state_e;

    // Accumulator width that cannot overflow when summing n values of base_w bits.
    function automatic int acc_width(input int base_w, input int n);
        return base_w + $clog2(n);
    endfunction

    // Clamp v into [0, 2^(w-1)-1].
    function automatic logic signed [63:0] ln_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (v < 64'sd0) begin
            return '0;
        end else if (v > max_v) begin
            return max_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/ln_lane_reducer.sv
// rtl/ln_lane_reducer.sv - combinational per-beat sum and sum of squares across lanes
module ln_lane_reducer
    import ln_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SUM_W      = 22,
    parameter int SQ_W       = 38
) (
    input  logic [LANES*DATA_WIDTH-1:0] i_data,
    output logic signed [SUM_W-1:0]     o_sum,
    output logic [SQ_W-1:0]             o_sumsq
);

    logic signed [SUM_W-1:0]      w_ext[LANES];
    logic [2*DATA_WIDTH-1:0]      w_sq[LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]   w_lane;
        logic signed [2*DATA_WIDTH-1:0] w_wide;
        assign w_lane   = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_wide   = {{DATA_WIDTH{w_lane[DATA_WIDTH-1]}}, w_lane};
        assign w_ext[k] = SUM_W'(w_lane);
        // A square of a DATA_WIDTH-bit signed value fits in 2*DATA_WIDTH bits and is never negative.
        assign w_sq[k]  = w_wide * w_wide;
    end

    // Sum all lanes of the beat; the tool balances the chain into an adder tree.
    always_comb begin
        o_sum   = '0;
        o_sumsq = '0;
        for (int k = 0; k < LANES; k++) begin
            o_sum   = o_sum + w_ext[k];
            o_sumsq = o_sumsq + SQ_W'(w_sq[k]);
        end
    end

endmodule

// File: rtl/ln_stats_stream.sv
// rtl/ln_stats_stream.sv - single-pass mean/variance engine; LN_STATS_EPS_EN adds EPS to variance
module ln_stats_stream
    import ln_pkg::*;
#(
    parameter int D_MODEL    = 64,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MEAN_WIDTH = 24,
    parameter int VAR_WIDTH  = 24,
    parameter int EPS        = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data_flat,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic signed [MEAN_WIDTH-1:0]  mean_out,
    output logic signed [VAR_WIDTH-1:0]   var_out,
    output logic                          out_err,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int BEATS  = D_MODEL / LANES;
    localparam int LOG2_D = $clog2(D_MODEL);
    localparam int SUM_W  = acc_width(DATA_WIDTH, D_MODEL);
    localparam int SQ_W   = acc_width(2 * DATA_WIDTH, D_MODEL);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef LN_STATS_EPS_EN
    localparam bit EPS_EN = 1'b1;
`else
    localparam bit EPS_EN = 1'b0;
`endif

    ln_state_e                    r_state;
    logic signed [SUM_W-1:0]      r_sum;
    logic [SQ_W-1:0]              r_sumsq;
    logic [CNT_W-1:0]             r_beat_cnt;
    logic                         r_err;
    logic signed [MEAN_WIDTH-1:0] r_mean;
    logic [SQ_W-1:0]              r_ex2;
    logic signed [VAR_WIDTH-1:0]  r_var;
    logic                         r_in_ready;
    logic                         r_out_valid;

    logic signed [SUM_W-1:0]      w_beat_sum;
    logic [SQ_W-1:0]              w_beat_sq;
    logic                         w_fire;
    logic                         w_is_last_beat;
    logic                         w_last_bad;
    logic signed [SUM_W-1:0]      w_mean_floor;
    logic signed [MEAN_WIDTH-1:0] w_mean_trunc;
    logic [SQ_W-1:0]              w_ex2;
    logic signed [63:0]           w_mean_sq;
    logic signed [63:0]           w_var_raw;
    logic signed [63:0]           w_var_clamped;
    logic signed [63:0]           w_var_pre_sat;
    logic signed [VAR_WIDTH-1:0]  w_var_next;

    ln_lane_reducer #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_W      (SUM_W),
        .SQ_W       (SQ_W)
    ) u_reducer (
        .i_data  (in_data_flat),
        .o_sum   (w_beat_sum),
        .o_sumsq (w_beat_sq)
    );

    assign w_fire         = in_valid && r_in_ready;
    assign w_is_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_last_bad     = (in_last != w_is_last_beat);

    // Division by D_MODEL is a shift: arithmetic (floor) for the mean, logical for E[x^2].
    assign w_mean_floor   = r_sum >>> LOG2_D;
    assign w_mean_trunc   = MEAN_WIDTH'(w_mean_floor);
    assign w_ex2          = r_sumsq >> LOG2_D;

    // Variance uses the already-truncated mean so mean_out and var_out stay consistent.
    assign w_mean_sq      = 64'(r_mean) * 64'(r_mean);
    assign w_var_raw      = $signed(64'(r_ex2)) - w_mean_sq;
    assign w_var_clamped  = (w_var_raw < 64'sd0) ? 64'sd0 : w_var_raw;
    assign w_var_pre_sat  = EPS_EN ? (w_var_clamped + 64'(EPS)) : w_var_raw;
    assign w_var_next     = VAR_WIDTH'(ln_sat(w_var_pre_sat, VAR_WIDTH));

    // Control FSM: accumulate beats, then two compute cycles, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_sum       <= '0;
            r_sumsq     <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
            r_mean      <= '0;
            r_ex2       <= '0;
            r_var       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_fire) begin
                        r_sum   <= r_sum + w_beat_sum;
                        r_sumsq <= r_sumsq + w_beat_sq;
                        if (w_last_bad) begin
                            r_err <= 1'b1;
                        end
                        // The count, not in_last, decides where the vector ends.
                        if (w_is_last_beat) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_MEAN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_MEAN: begin
                    r_mean  <= w_mean_trunc;
                    r_ex2   <= w_ex2;
                    r_state <= ST_VAR;
                end
                ST_VAR: begin
                    r_var       <= w_var_next;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_sum       <= '0;
                        r_sumsq     <= '0;
                        r_beat_cnt  <= '0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign mean_out  = r_mean;
    assign var_out   = r_var;
    assign out_err   = r_err;

endmodule

// File: tb/tb_ln_stats_stream.sv
// tb/tb_ln_stats_stream.sv - randomized self-checking bench with a behavioural statistics model
module tb_ln_stats_stream;

    localparam int D_MODEL = 64;
    localparam int LANES   = 4;
    localparam int DW      = 16;
    localparam int MW      = 24;
    localparam int VW      = 24;
    localparam int BEATS   = D_MODEL / LANES;
    localparam longint VMAX = 64'd8388607;
`ifdef LN_STATS_EPS_EN
    localparam int EPS = 10;
`else
    localparam int EPS = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LANES*DW-1:0]    in_data_flat;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic signed [MW-1:0]   mean_out;
    logic signed [VW-1:0]   var_out;
    logic                   out_err;
    logic                   out_valid;
    logic                   out_ready = 1'b1;

    ln_stats_stream #(
        .D_MODEL(D_MODEL), .LANES(LANES), .DATA_WIDTH(DW),
        .MEAN_WIDTH(MW), .VAR_WIDTH(VW), .EPS(EPS)
    ) u_dut (
        .clk(clk), .rst(rst), .in_data_flat(in_data_flat), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .mean_out(mean_out), .var_out(var_out),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint mean;
        longint var_v;
        bit     err;
        int     tacc;
    } exp_t;

    exp_t   q[$];
    longint vec[D_MODEL];
    bit     lastpat[BEATS];
    int     n_pass = 0;
    int     n_total = 0;
    int     cyc = 0;
    int     last_tacc = 0;
    int     or_mode = 0;
    bit     in_result = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Statistics straight from the definitions: floor mean, E[x^2] - mean^2, clamp, saturate.
    function automatic exp_t model_vec();
        exp_t   e;
        longint sum = 0;
        longint sq = 0;
        longint m;
        longint v;
        for (int i = 0; i < D_MODEL; i++) begin
            sum += vec[i];
            sq  += vec[i] * vec[i];
        end
        m = sum / D_MODEL;
        if ((sum % D_MODEL) != 0 && sum < 0) m = m - 1;
        v = (sq / D_MODEL) - m * m;
        if (v < 0) v = 0;
`ifdef LN_STATS_EPS_EN
        v = v + EPS;
`endif
        if (v > VMAX) v = VMAX;
        if (v < 0) v = 0;
        e.mean  = m;
        e.var_v = v;
        e.err   = 1'b0;
        for (int b = 0; b < BEATS; b++)
            if (lastpat[b] != (b == BEATS - 1)) e.err = 1'b1;
        e.tacc = 0;
        return e;
    endfunction

    function automatic void clean_last();
        for (int b = 0; b < BEATS; b++) lastpat[b] = (b == BEATS - 1);
    endfunction

    function automatic void rand_vec();
        for (int i = 0; i < D_MODEL; i++) vec[i] = longint'($urandom_range(65535)) - 32768;
    endfunction

    task automatic send_vec(input int nbeats, input int gap_pct);
        exp_t   e;
        longint tmp;
        bit     rdy;
        int     tneg;
        int     t;
        e = model_vec();
        for (int b = 0; b < nbeats; b++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            for (int k = 0; k < LANES; k++) begin
                tmp = vec[b*LANES + k];
                in_data_flat[k*DW +: DW] = tmp[DW-1:0];
            end
            in_valid = 1'b1;
            in_last  = lastpat[b];
            t = 0;
            forever begin
                @(negedge clk);
                rdy  = in_ready;
                tneg = cyc;
                @(posedge clk); #1;
                if (rdy) break;
                t++;
                if (t > 200) begin
                    check("in_ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            if (b == BEATS - 1) last_tacc = tneg;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (nbeats == BEATS) begin
            e.tacc = last_tacc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    // Consumer-side handshake pattern.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(1));
            default: out_ready = 1'b0;
        endcase
    end

    // Single compare process: every cycle with out_valid is checked against the model queue head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                if (!in_result) check("latency", cyc, q[0].tacc + 3);
                check("mean_out", mean_out, q[0].mean);
                check("var_out", var_out, q[0].var_v);
                check("out_err", out_err, q[0].err);
                check("in_ready_during_out", in_ready, 0);
                if (out_ready) begin
                    void'(q.pop_front());
                    in_result = 1'b0;
                end else begin
                    in_result = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   t_first;
        int   t;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data_flat = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_mean", mean_out, 0);
        check("reset_var", var_out, 0);
        check("reset_err", out_err, 0);
        @(posedge clk); #1;

        // {4096,3072,2048,1024} repeated
        for (int i = 0; i < D_MODEL; i++) vec[i] = 4096 - 1024 * (i % 4);
        clean_last();
        e = model_vec();
        check("pin_ramp_mean", e.mean, 2560);
        check("pin_ramp_var", e.var_v, 1310720 + EPS);
        check("pin_ramp_err", e.err, 0);
        send_vec(BEATS, 0);
        drain();

        // constant 2048, two vectors back to back for throughput
        for (int i = 0; i < D_MODEL; i++) vec[i] = 2048;
        e = model_vec();
        check("pin_const_mean", e.mean, 2048);
        check("pin_const_var", e.var_v, EPS);
        send_vec(BEATS, 0);
        t_first = last_tacc;
        send_vec(BEATS, 0);
        check("throughput", last_tacc - t_first, BEATS + 3);
        drain();

        // alternating -1024 / 1024
        for (int i = 0; i < D_MODEL; i++) vec[i] = (i % 2 == 0) ? -1024 : 1024;
        e = model_vec();
        check("pin_alt_mean", e.mean, 0);
        check("pin_alt_var", e.var_v, 1048576 + EPS);
        send_vec(BEATS, 0);
        drain();

        // single -1: floor mean, variance clamps to zero
        for (int i = 0; i < D_MODEL; i++) vec[i] = 0;
        vec[0] = -1;
        e = model_vec();
        check("pin_floor_mean", e.mean, -1);
        check("pin_floor_var", e.var_v, EPS);
        send_vec(BEATS, 0);
        drain();

        // full-scale alternation saturates the variance
        for (int i = 0; i < D_MODEL; i++) vec[i] = (i % 2 == 0) ? -32768 : 32767;
        e = model_vec();
        check("pin_sat_mean", e.mean, -1);
        check("pin_sat_var", e.var_v, VMAX);
        send_vec(BEATS, 0);
        drain();

        // backpressure: hold out_ready low while the result is presented
        or_mode = 3;
        rand_vec();
        send_vec(BEATS, 0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        repeat (5) @(negedge clk);
        or_mode = 0;
        rand_vec();
        send_vec(BEATS, 0);
        drain();

        // early in_last on beat 2, missing on beat 15
        rand_vec();
        clean_last();
        lastpat[2] = 1'b1;
        lastpat[BEATS-1] = 1'b0;
        e = model_vec();
        check("pin_err_flag", e.err, 1);
        send_vec(BEATS, 0);
        rand_vec();
        clean_last();
        e = model_vec();
        check("pin_clean_err", e.err, 0);
        send_vec(BEATS, 0);
        drain();

        // reset after 5 of 16 beats aborts the vector
        rand_vec();
        send_vec(5, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_out_valid", out_valid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        for (int i = 0; i < D_MODEL; i++) vec[i] = 2048;
        e = model_vec();
        check("pin_after_abort_var", e.var_v, EPS);
        send_vec(BEATS, 0);
        drain();

        // randomized traffic on both sides
        or_mode = 1;
        for (int n = 0; n < 30; n++) begin
            rand_vec();
            if (n % 5 == 0)
                for (int i = 0; i < D_MODEL; i++) vec[i] = vec[i] / 64 + 3000;
            clean_last();
            if ($urandom_range(99) < 15) begin
                t = int'($urandom_range(BEATS - 1));
                lastpat[t] = ~lastpat[t];
            end
            send_vec(BEATS, 30);
        end
        or_mode = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
